// File: rtl/alarm_clock_pkg.sv
// Shared types and helpers for the alarm clock controller: mode and alarm
// state encodings plus the active-low seven-segment decoder.
package alarm_clock_pkg;

    typedef enum logic [1:0] {RUN, SET_TIME, SET_ALARM} mode_t;
    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} alarm_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Segment order is {g,f,e,d,c,b,a}; a zero bit lights the segment.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// one-cycle press pulse on the accepted 1->0 transition of an active-low key.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] count;

    // The counter only runs while the synchronized level disagrees with the
    // accepted level, so any bounce back restarts the stability window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                count <= '0;
            end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
                count  <= '0;
                stable <= sync2;
                press  <= ~sync2;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock controller: BCD timekeeping, mode and alarm state machines,
// buzzer drive and registered active-low seven-segment outputs.
module alarm_clock_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int RING_SEC        = 60,
    parameter int SNOOZE_MIN      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
    input  logic       alarm1,
    output logic [1:0] buzzer,
    output logic [6:0] segment1,
    output logic [6:0] segment2,
    output logic [6:0] segment3,
    output logic [6:0] segment4
);

    localparam int PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SNOOZE_SEC = SNOOZE_MIN * 60;
    localparam int RW         = $clog2(RING_SEC + 1);
    localparam int SW         = $clog2(SNOOZE_SEC + 1);

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] limit);
        logic [7:0] r;
        if (v == limit)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    logic [PW-1:0] presc;
    logic          tick;
    logic          blink_on;
    logic          alarm_sync1;
    logic          alarm_en;
    logic [3:0]    keys;
    logic [3:0]    press;

    mode_t         mode, mode_next;
    alarm_t        alarm_state, alarm_next;
    logic [RW-1:0] ring_cnt, ring_next;
    logic [SW-1:0] snooze_cnt, snooze_next;

    logic [7:0]    sec, min, hr, alm_min, alm_hr;
    logic [7:0]    sec_next, min_next, hr_next, alm_min_next, alm_hr_next;
    logic          advance;
    logic          keys_free;
    logic          trigger;
    logic [15:0]   disp;
    logic          blank;

    assign tick     = (presc == PW'(CLK_HZ - 1));
    assign blink_on = (presc < PW'(CLK_HZ / 2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc       <= '0;
            alarm_sync1 <= 1'b0;
            alarm_en    <= 1'b0;
        end else begin
            presc       <= tick ? '0 : presc + PW'(1);
            alarm_sync1 <= alarm1;
            alarm_en    <= alarm_sync1;
        end
    end

    assign keys = {button4, button3, button2, button1};

    for (genvar i = 0; i < 4; i++) begin : g_keys
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
            .clk   (clk),
            .reset (reset),
            .button(keys[i]),
            .press (press[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode        <= RUN;
            alarm_state <= IDLE;
            ring_cnt    <= '0;
            snooze_cnt  <= '0;
            sec         <= 8'h00;
            min         <= 8'h00;
            hr          <= 8'h00;
            alm_min     <= 8'h00;
            alm_hr      <= 8'h00;
        end else begin
            mode        <= mode_next;
            alarm_state <= alarm_next;
            ring_cnt    <= ring_next;
            snooze_cnt  <= snooze_next;
            sec         <= sec_next;
            min         <= min_next;
            hr          <= hr_next;
            alm_min     <= alm_min_next;
            alm_hr      <= alm_hr_next;
        end
    end

    always_comb begin
        mode_next = mode;
        if (press[0]) begin
            unique case (mode)
                RUN:      mode_next = SET_TIME;
                SET_TIME: mode_next = SET_ALARM;
                default:  mode_next = RUN;
            endcase
        end
    end

    // Ringing owns keys 2..4, so edits are suppressed only in that state.
    always_comb begin
        sec_next     = sec;
        min_next     = min;
        hr_next      = hr;
        alm_min_next = alm_min;
        alm_hr_next  = alm_hr;
        advance      = tick && (mode != SET_TIME);
        keys_free    = (alarm_state != RINGING);
        if (advance) begin
            sec_next = bcd_inc(sec, 8'h59);
            if (sec == 8'h59) begin
                min_next = bcd_inc(min, 8'h59);
                if (min == 8'h59)
                    hr_next = bcd_inc(hr, 8'h23);
            end
        end
        if (keys_free && mode == SET_TIME) begin
            if (press[1])
                hr_next = bcd_inc(hr, 8'h23);
            if (press[2]) begin
                min_next = bcd_inc(min, 8'h59);
                sec_next = 8'h00;
            end
        end else if (keys_free && mode == SET_ALARM) begin
            if (press[1])
                alm_hr_next = bcd_inc(alm_hr, 8'h23);
            if (press[2])
                alm_min_next = bcd_inc(alm_min, 8'h59);
        end
    end

    assign trigger = advance && (sec_next == 8'h00) && alarm_en &&
                     ({hr_next, min_next} == {alm_hr, alm_min});

    // Stop wins over every other event; disarming overrides everything.
    always_comb begin
        alarm_next  = alarm_state;
        ring_next   = ring_cnt;
        snooze_next = snooze_cnt;
        unique case (alarm_state)
            IDLE: begin
                if (trigger) begin
                    alarm_next = RINGING;
                    ring_next  = RW'(RING_SEC);
                end
            end
            RINGING: begin
                if (press[3]) begin
                    alarm_next = IDLE;
                end else if (press[1] || press[2]) begin
                    alarm_next  = SNOOZE;
                    snooze_next = SW'(SNOOZE_SEC);
                end else if (tick) begin
                    if (ring_cnt <= RW'(1))
                        alarm_next = IDLE;
                    else
                        ring_next = ring_cnt - RW'(1);
                end
            end
            SNOOZE: begin
                if (press[3]) begin
                    alarm_next = IDLE;
                end else if (tick) begin
                    if (snooze_cnt <= SW'(1)) begin
                        alarm_next = RINGING;
                        ring_next  = RW'(RING_SEC);
                    end else begin
                        snooze_next = snooze_cnt - SW'(1);
                    end
                end
            end
            default: alarm_next = IDLE;
        endcase
        if (!alarm_en)
            alarm_next = IDLE;
    end

    always_comb begin
        disp  = (mode == SET_ALARM) ? {alm_hr, alm_min} : {hr, min};
        blank = (mode != RUN) && !blink_on;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buzzer   <= 2'b00;
            segment1 <= 7'b1000000;
            segment2 <= 7'b1000000;
            segment3 <= 7'b1000000;
            segment4 <= 7'b1000000;
        end else begin
            buzzer[1] <= (alarm_state == RINGING) || (alarm_state == SNOOZE);
            buzzer[0] <= (alarm_state == RINGING) && blink_on;
            segment1  <= blank ? SEG_BLANK : bcd_to_seg(disp[15:12]);
            segment2  <= blank ? SEG_BLANK : bcd_to_seg(disp[11:8]);
            segment3  <= blank ? SEG_BLANK : bcd_to_seg(disp[7:4]);
            segment4  <= blank ? SEG_BLANK : bcd_to_seg(disp[3:0]);
        end
    end

endmodule
